add_display_arb: RTL and testbench

ADD_DISPLAY_ARB -- requirements
Module: add_display_arb

---
 rtl/add_display_arb.sv | 110 +++++++++++
 tb/tb_add_display_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_display_arb.sv
// Two-requester round-robin adder that shows a+b on a 7-segment display for HOLD_CYCLES cycles.
// Optional macro ADD_DISP_BLANK_EN: blank the display whenever the arbiter is idle.
module add_display_arb #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    output logic       req1_ready,
    output logic [6:0] seg,
    output logic       src,
    output logic       busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    state_t      state, state_nxt;
    logic [15:0] hold_cnt;
    logic        last_grant;
    logic        grant;
    logic        grant_id;
    logic [2:0]  op_a, op_b;
    logic [3:0]  sum;

    function automatic logic [6:0] seg_of(input logic [3:0] value);
        case (value)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            4'd10:   seg_of = 7'b0001000;
            4'd11:   seg_of = 7'b0000011;
            4'd12:   seg_of = 7'b1000110;
            4'd13:   seg_of = 7'b0100001;
            4'd14:   seg_of = 7'b0000110;
            default: seg_of = 7'b0111000;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant     = 1'b1;
                    // On a tie the requester not granted last wins.
                    grant_id  = req1_valid && (!req0_valid || !last_grant);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == 16'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is combinational from valid, so it must also be held low while reset is asserted.
    assign req0_ready = rst_n && grant && !grant_id;
    assign req1_ready = rst_n && grant && grant_id;
    assign busy       = (state == HOLD);

    assign op_a = grant_id ? req1_a : req0_a;
    assign op_b = grant_id ? req1_b : req0_b;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= 16'd0;
            last_grant <= 1'b1;
            seg        <= SEG_BLANK;
            src        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                hold_cnt   <= HOLD_LOAD;
                last_grant <= grant_id;
                src        <= grant_id;
                seg        <= seg_of(sum);
            end else if (state == HOLD && hold_cnt != 16'd0) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
`ifdef ADD_DISP_BLANK_EN
            if (state == HOLD && hold_cnt == 16'd0) seg <= SEG_BLANK;
`else
`endif
        end
    end

endmodule

// File: tb/tb_add_display_arb.sv
// Randomized and directed bench for add_display_arb against a cycle-level behavioural model.
module tb_add_display_arb;

    localparam int HOLD = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0111000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [2:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       r0, r1, src, busy;
    logic [6:0] seg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gid[$];
    int gcyc[$];

    add_display_arb #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
        .seg(seg), .src(src), .busy(busy));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: remaining display cycles, who was served last, what is shown.
    int         m_hold = 0;
    int         m_last = 1;
    logic [6:0] m_seg  = 7'b1111111;
    int         m_src  = 0;

    function automatic int winner(input logic p0, input logic p1, input int last_served);
        if (p0 && p1) return (last_served == 0) ? 1 : 0;
        return p1 ? 1 : 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_hold = 0; m_last = 1; m_seg = 7'b1111111; m_src = 0;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
`ifdef ADD_DISP_BLANK_EN
            if (m_hold == 0) m_seg = 7'b1111111;
`endif
        end else if (v0 || v1) begin
            m_src  = winner(v0, v1, m_last);
            m_last = m_src;
            m_hold = HOLD;
            m_seg  = (m_src == 1) ? SEG_TAB[int'(a1) + int'(b1)] : SEG_TAB[int'(a0) + int'(b0)];
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial forever begin
        logic e0, e1;
        @(negedge clk);
        cyc++;
        e0 = rst_n && m_hold == 0 && (v0 || v1) && winner(v0, v1, m_last) == 0;
        e1 = rst_n && m_hold == 0 && (v0 || v1) && winner(v0, v1, m_last) == 1;
        check("ready0", r0, e0);
        check("ready1", r1, e1);
        check("busy", busy, m_hold > 0);
        check("seg", seg, m_seg);
        check("src", src, m_src);
        if (r0) begin gid.push_back(0); gcyc.push_back(cyc); end
        if (r1) begin gid.push_back(1); gcyc.push_back(cyc); end
    end

    task automatic drive_pt; @(posedge clk); #2; endtask
    task automatic peek;     @(negedge clk); #1; endtask

    task automatic do_req(input int idx, input logic [2:0] a, input logic [2:0] b);
        bit got = 0;
        drive_pt;
        if (idx == 1) begin v1 = 1; a1 = a; b1 = b; end
        else begin v0 = 1; a0 = a; b0 = b; end
        for (int i = 0; i < 4 * HOLD + 8; i++) begin
            peek;
            if ((idx == 1) ? r1 : r0) begin got = 1; break; end
            drive_pt;
        end
        check($sformatf("req%0d_granted", idx), got, 1);
        drive_pt;
        if (idx == 1) v1 = 0; else v0 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int gap;
        bit pend0, pend1, rst_pulse;
        logic s0, s1;

        repeat (3) drive_pt;
        peek;
        check("rst_seg", seg, 7'b1111111);
        check("rst_busy", busy, 0);
        check("rst_src", src, 0);
        drive_pt; rst_n = 1;

        // Tie right after reset: requester 0 first, requester 1 in the next idle cycle.
        drive_pt;
        v0 = 1; a0 = 7; b0 = 7; v1 = 1; a1 = 1; b1 = 0;
        peek;
        check("tie_r0", r0, 1);
        check("tie_r1", r1, 0);
        drive_pt; v0 = 0;
        peek;
        check("tie_seg0", seg, 7'b0000110);
        check("tie_src0", src, 0);
        check("tie_busy", busy, 1);
        found = 0; gap = 0;
        for (int i = 0; i < 20; i++) begin
            drive_pt; peek;
            if (r1) begin found = 1; gap = i; break; end
        end
        check("rr_found", found, 1);
        check("rr_gap", gap, HOLD - 1);
        drive_pt; v1 = 0;
        peek;
        check("rr_seg1", seg, 7'b1111001);
        check("rr_src1", src, 1);

        // Single request 3+4: shown for exactly HOLD cycles.
        do_req(0, 3, 4);
        for (int k = 0; k < HOLD; k++) begin
            peek;
            check("hold_busy", busy, 1);
            check("hold_seg7", seg, 7'b1111000);
            check("hold_src", src, 0);
            drive_pt;
        end
        peek;
        check("after_hold_busy", busy, 0);
`ifdef ADD_DISP_BLANK_EN
        check("after_hold_seg", seg, 7'b1111111);
`else
        check("after_hold_seg", seg, 7'b1111000);
`endif

        // 2+3 via requester 1, then the idle display.
        do_req(1, 2, 3);
        peek;
        check("five_seg", seg, 7'b0010010);
        repeat (HOLD) begin drive_pt; peek; end
        check("five_idle_busy", busy, 0);
`ifdef ADD_DISP_BLANK_EN
        check("five_idle_seg", seg, 7'b1111111);
`else
        check("five_idle_seg", seg, 7'b0010010);
`endif

        // Both valids held: alternating grants every HOLD+1 cycles, requester 0 first.
        gid.delete(); gcyc.delete();
        drive_pt;
        v0 = 1; v1 = 1;
        a0 = 3'($urandom); b0 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
        repeat (4 * (HOLD + 1) + 1) @(posedge clk);
        #2; v0 = 0; v1 = 0;
        check("alt_count_ok", gid.size() >= 4, 1);
        if (gid.size() >= 1) check("alt_first", gid[0], 0);
        for (int j = 1; j < gid.size(); j++) begin
            check("alt_id", gid[j], 1 - gid[j-1]);
            check("alt_period", gcyc[j] - gcyc[j-1], HOLD + 1);
        end

        // Reset pulse in the middle of a display.
        do_req(0, 5, 5);
        peek;
        drive_pt;
        rst_n = 0;
        #1;
        check("midrst_seg", seg, 7'b1111111);
        check("midrst_busy", busy, 0);
        check("midrst_src", src, 0);
        drive_pt; rst_n = 1;
        peek;
        check("postrst_busy", busy, 0);
        drive_pt; v0 = 1; v1 = 1; a0 = 1; b0 = 1; a1 = 2; b1 = 2;
        peek;
        check("postrst_tie_r0", r0, 1);
        drive_pt; v0 = 0; v1 = 0;

        // Sweep all operand pairs through requester 1.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_req(1, 3'(a), 3'(b));
                peek;
                check($sformatf("sweep_%0d_%0d", a, b), seg, SEG_TAB[a + b]);
            end
        end

        // Random traffic honouring the hold-until-ready rule, with rare reset pulses.
        pend0 = 0; pend1 = 0; rst_pulse = 0; s0 = 0; s1 = 0;
        for (int n = 0; n < 400; n++) begin
            drive_pt;
            if (rst_pulse) begin rst_n = 1; rst_pulse = 0; end
            else if ($urandom_range(0, 79) == 0) begin rst_n = 0; rst_pulse = 1; end
            if (s0) pend0 = 0;
            if (s1) pend1 = 0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1; a0 = 3'($urandom); b0 = 3'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; a1 = 3'($urandom); b1 = 3'($urandom);
            end
            v0 = pend0; v1 = pend1;
            peek;
            s0 = r0; s1 = r1;
        end
        drive_pt;
        v0 = 0; v1 = 0; rst_n = 1;
        drive_pt;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
